multi_walk_voice: RTL

MULTI_WALK_VOICE -- requirements
Module: multi_walk_voice

---
 rtl/multi_walk_voice.sv | 214 +++++++++++++++++++++
 1 files changed

// File: rtl/multi_walk_voice.sv
// Multi-channel "walk" voice: per-channel slewed gate, square LFO, pulse VCO,
// leaky high-pass and diode shaper, time-multiplexed through one datapath and mixed.
module multi_walk_voice #(
    parameter int CHANNELS         = 2,
    parameter int WIDTH            = 16,
    parameter int GATE_LEVEL       = 6826,
    parameter int EN_ACTIVE_LOW    = 1,
    parameter int SLEW_STEP        = 20,
    parameter int LFO_HALF_SAMPLES = 240,
    parameter int VCO_BASE_INC     = 1024,
    parameter int VCO_DEPTH        = 512,
    parameter int HP_SHIFT         = 6,
    parameter int MIX_SHIFT        = 1
) (
    input  logic                    clk,
    input  logic                    I_RST,
    input  logic                    audio_clk_en,
    input  logic [CHANNELS-1:0]     walk_en,
    output logic signed [WIDTH-1:0] out,
    output logic                    sample_valid,
    output logic [CHANNELS-1:0]     active,
    output logic                    overrun
);

    localparam int CW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
    localparam int SW = $clog2(CHANNELS + 1);
    localparam int AW = WIDTH + $clog2(CHANNELS) + 1;
    localparam int HW = WIDTH + 2;
    localparam int XW = (AW > HW) ? AW : HW;
    localparam int LW = (LFO_HALF_SAMPLES > 1) ? $clog2(LFO_HALF_SAMPLES) : 1;

    localparam logic signed [XW-1:0]    MAX_X     = XW'((2 ** (WIDTH - 1)) - 1);
    localparam logic signed [XW-1:0]    MIN_X     = ~MAX_X;
    localparam logic signed [WIDTH-1:0] MAX_W     = MAX_X[WIDTH-1:0];
    localparam logic signed [WIDTH-1:0] MIN_W     = ~MAX_W;
    localparam logic signed [XW-1:0]    GATE_X    = XW'(GATE_LEVEL);
    localparam logic signed [WIDTH-1:0] GATE_W    = GATE_X[WIDTH-1:0];
    localparam logic signed [XW-1:0]    SLEW_X    = XW'(SLEW_STEP);
    localparam logic [15:0]             BASE_INC  = 16'(VCO_BASE_INC);
    localparam logic [15:0]             DEPTH_INC = 16'(VCO_DEPTH);
    localparam logic [LW-1:0]           LFO_LAST  = LW'(LFO_HALF_SAMPLES - 1);

    typedef enum logic [1:0] {ST_IDLE, ST_ATTACK, ST_ACTIVE, ST_RELEASE} state_t;

    function automatic logic signed [WIDTH-1:0] sat(input logic signed [XW-1:0] v);
        if (v > MAX_X)      return MAX_W;
        else if (v < MIN_X) return MIN_W;
        else                return v[WIDTH-1:0];
    endfunction

    // Sequencer and output registers
    logic                    busy_q, busy_d;
    logic [SW-1:0]           step_q, step_d;
    logic signed [XW-1:0]    acc_q, acc_d;
    logic signed [WIDTH-1:0] out_q, out_d;
    logic                    valid_q, valid_d;
    logic                    overrun_q, overrun_d;

    // Per-channel state
    logic signed [WIDTH-1:0] g_q [CHANNELS];
    logic signed [WIDTH-1:0] g_d [CHANNELS];
    state_t                  st_q [CHANNELS];
    state_t                  st_d [CHANNELS];
    logic [LW-1:0]           lfo_q [CHANNELS];
    logic [LW-1:0]           lfo_d [CHANNELS];
    logic                    sq_q [CHANNELS];
    logic                    sq_d [CHANNELS];
    logic [15:0]             phase_q [CHANNELS];
    logic [15:0]             phase_d [CHANNELS];
    logic signed [WIDTH-1:0] e_prev_q [CHANNELS];
    logic signed [WIDTH-1:0] e_prev_d [CHANNELS];
    logic signed [WIDTH-1:0] h_prev_q [CHANNELS];
    logic signed [WIDTH-1:0] h_prev_d [CHANNELS];

    logic                    proc, last_ch, en_ch, up, down;
    logic [CW-1:0]           cur;
    logic signed [XW-1:0]    tgt_x, g_x, diff_x, mag_x, h_x, hs_x, s_x, mix_x, mix_sh;
    logic signed [WIDTH-1:0] g_new, e_new, h_new, s_new;
    state_t                  st_new;
    logic [LW-1:0]           lfo_new;
    logic                    sq_new;
    logic [15:0]             phase_new;

    always_comb begin
        busy_d    = busy_q;
        step_d    = step_q;
        overrun_d = overrun_q;
        if (!busy_q) begin
            if (audio_clk_en) begin
                busy_d = 1'b1;
                step_d = '0;
            end
        end else begin
            if (audio_clk_en) overrun_d = 1'b1;
            if (step_q == SW'(CHANNELS)) busy_d = 1'b0;
            else                         step_d = step_q + SW'(1);
        end
    end

    assign proc    = busy_q && (step_q < SW'(CHANNELS));
    assign last_ch = busy_q && (step_q == SW'(CHANNELS - 1));
    assign cur     = step_q[CW-1:0];

    // Shared per-channel datapath, operating on the channel selected by cur
    always_comb begin
        en_ch  = (EN_ACTIVE_LOW != 0) ? ~walk_en[cur] : walk_en[cur];
        tgt_x  = en_ch ? GATE_X : '0;
        g_x    = XW'(g_q[cur]);
        diff_x = tgt_x - g_x;
        down   = diff_x[XW-1];
        up     = !down && (diff_x != '0);
        mag_x  = down ? -diff_x : diff_x;
        if (mag_x > SLEW_X) mag_x = SLEW_X;
        g_new  = down ? WIDTH'(g_x - mag_x) : WIDTH'(g_x + mag_x);

        st_new = st_q[cur];
        case (st_q[cur])
            ST_IDLE:    if (up) st_new = ST_ATTACK;
            ST_ATTACK:  if (down) st_new = ST_RELEASE;
                        else if (g_new == GATE_W) st_new = ST_ACTIVE;
            ST_ACTIVE:  if (down) st_new = ST_RELEASE;
            ST_RELEASE: if (up) st_new = ST_ATTACK;
                        else if (g_new == '0) st_new = ST_IDLE;
        endcase

        lfo_new   = (lfo_q[cur] == LFO_LAST) ? '0 : lfo_q[cur] + LW'(1);
        sq_new    = (lfo_q[cur] == LFO_LAST) ? ~sq_q[cur] : sq_q[cur];
        phase_new = phase_q[cur] + BASE_INC + (sq_q[cur] ? DEPTH_INC : 16'd0);
        e_new     = phase_new[15] ? g_new : '0;

        h_x   = XW'(e_new) - XW'(e_prev_q[cur]) + XW'(h_prev_q[cur])
              - XW'(h_prev_q[cur] >>> HP_SHIFT);
        h_new = sat(h_x);
        hs_x  = XW'(h_new);
        // Diode: positive half gets 1.5x gain, negative half 0.75x.
        if (!h_new[WIDTH-1] && (h_new != '0)) s_x = hs_x + (hs_x >>> 1);
        else                                  s_x = (hs_x >>> 1) + (hs_x >>> 2);
        s_new = sat(s_x);

        mix_x  = ((step_q == '0) ? '0 : acc_q) + XW'(s_new);
        mix_sh = mix_x >>> MIX_SHIFT;
        acc_d  = proc ? mix_x : acc_q;
        out_d  = last_ch ? sat(mix_sh) : out_q;
        valid_d = last_ch;

        for (int i = 0; i < CHANNELS; i++) begin
            g_d[i]      = g_q[i];
            st_d[i]     = st_q[i];
            lfo_d[i]    = lfo_q[i];
            sq_d[i]     = sq_q[i];
            phase_d[i]  = phase_q[i];
            e_prev_d[i] = e_prev_q[i];
            h_prev_d[i] = h_prev_q[i];
        end
        if (proc) begin
            g_d[cur]      = g_new;
            st_d[cur]     = st_new;
            lfo_d[cur]    = lfo_new;
            sq_d[cur]     = sq_new;
            phase_d[cur]  = phase_new;
            e_prev_d[cur] = e_new;
            h_prev_d[cur] = h_new;
        end
    end

    always_ff @(posedge clk) begin
        if (I_RST) begin
            busy_q    <= 1'b0;
            step_q    <= '0;
            acc_q     <= '0;
            out_q     <= '0;
            valid_q   <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            busy_q    <= busy_d;
            step_q    <= step_d;
            acc_q     <= acc_d;
            out_q     <= out_d;
            valid_q   <= valid_d;
            overrun_q <= overrun_d;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < CHANNELS; gi++) begin : g_chan
            always_ff @(posedge clk) begin
                if (I_RST) begin
                    g_q[gi]      <= '0;
                    st_q[gi]     <= ST_IDLE;
                    lfo_q[gi]    <= '0;
                    sq_q[gi]     <= 1'b0;
                    phase_q[gi]  <= '0;
                    e_prev_q[gi] <= '0;
                    h_prev_q[gi] <= '0;
                end else begin
                    g_q[gi]      <= g_d[gi];
                    st_q[gi]     <= st_d[gi];
                    lfo_q[gi]    <= lfo_d[gi];
                    sq_q[gi]     <= sq_d[gi];
                    phase_q[gi]  <= phase_d[gi];
                    e_prev_q[gi] <= e_prev_d[gi];
                    h_prev_q[gi] <= h_prev_d[gi];
                end
            end
            assign active[gi] = (st_q[gi] != ST_IDLE);
        end
    endgenerate

    assign out          = out_q;
    assign sample_valid = valid_q;
    assign overrun      = overrun_q;

endmodule
